// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one cacheline-adaptor port between I-cache and D-cache miss traffic.
// A grant is held until the adaptor's mem_resp pulse, then one IDLE cycle separates grants.
module cache_mem_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = I served last, 1 = D served last
  logic   i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = last_grant_q ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs depend only on the registered state plus the granted side's inputs,
  // so an asynchronous reset (state -> IDLE) zeroes them immediately.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_rdata     = '0;
    d_rdata     = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (state_q)
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_rdata     = mem_rdata;
        i_resp      = mem_resp;
      end
      SERVE_D: begin
        mem_read    = d_read & ~d_write;
        mem_write   = d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_rdata     = mem_rdata;
        d_resp      = mem_resp;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // A granted requester must keep its request up until its resp.
  a_i_hold: assert property (@(posedge clk) disable iff (!rst)
                             (state_q == SERVE_I) |-> i_req);
  a_d_hold: assert property (@(posedge clk) disable iff (!rst)
                             (state_q == SERVE_D) |-> d_req);
  a_rw_excl: assert property (@(posedge clk) disable iff (!rst)
                              !(mem_read && mem_write));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// protocol-compliant traffic compared against a grant-level reference model.
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int VW = 4 + AW + 3 * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: who currently owns the memory port (0 none, 1 I, 2 D)
  // and whether D was the most recently completed transfer.
  int owner = 0;
  bit last_d = 1'b0;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner  <= 0;
      last_d <= 1'b0;
    end else if (owner == 0) begin
      if (i_read && (d_read || d_write)) owner <= last_d ? 1 : 2;
      else if (i_read) owner <= 1;
      else if (d_read || d_write) owner <= 2;
    end else if (mem_resp) begin
      last_d <= (owner == 2);
      owner  <= 0;
    end
  end

  function automatic logic [VW-1:0] dut_vec();
    return {mem_read, mem_write, mem_address, mem_wdata, i_resp, d_resp, i_rdata, d_rdata};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic mr, mw, ir_s, dr_s;
    logic [AW-1:0] a;
    logic [LW-1:0] wd, ir, dr;
    mr = 1'b0; mw = 1'b0; ir_s = 1'b0; dr_s = 1'b0;
    a = '0; wd = '0; ir = '0; dr = '0;
    if (rst && owner == 1) begin
      mr = 1'b1; a = i_address; ir = mem_rdata; ir_s = mem_resp;
    end else if (rst && owner == 2) begin
      mw = d_write; mr = d_read && !d_write; a = d_address; wd = d_wdata;
      dr = mem_rdata; dr_s = mem_resp;
    end
    return {mr, mw, a, wd, ir_s, dr_s, ir, dr};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b1; d_write = 1'b1; mem_resp = 1'b1;
    i_address = 32'h0000_0040; d_address = 32'h0000_0080;
    d_wdata = rand_line(); mem_rdata = rand_line();
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (dut_vec() !== '0)
        begin failures++; $display("FAIL reset_outputs act=%h req=0", dut_vec()); end
    end
    i_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (dut_vec() !== model_vec() || mem_read !== 1'b0)
      begin failures++; $display("FAIL reset_idle act=%h exp=%h", dut_vec(), model_vec()); end
  endtask

  task automatic test_i_alone();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0060; #1;
    checks++;
    if (mem_read !== 1'b0)
      begin failures++; $display("FAIL i_no_comb_forward mem_read=%b req=0", mem_read); end
    @(negedge clk); #1;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h60 || dut_vec() !== model_vec())
      begin failures++; $display("FAIL i_grant rd=%b addr=%h req rd=1 addr=60", mem_read, mem_address); end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = {32{8'hA5}}; #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== {32{8'hA5}} || d_resp !== 1'b0 || d_rdata !== '0)
      begin failures++; $display("FAIL i_resp resp=%b rdata=%h req resp=1 rdata=a5..", i_resp, i_rdata); end
    @(negedge clk);
    mem_resp = 1'b0; i_read = 1'b0; #1;
    checks++;
    if (mem_read !== 1'b0 || i_resp !== 1'b0 || dut_vec() !== model_vec())
      begin failures++; $display("FAIL i_back_idle rd=%b resp=%b req 0 0", mem_read, i_resp); end
  endtask

  task automatic test_priority();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_write = 1'b1; d_address = 32'h0000_0200; d_wdata = {8{32'h1234_5678}};
    @(negedge clk); #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h200 ||
        mem_wdata !== {8{32'h1234_5678}} || dut_vec() !== model_vec())
      begin failures++; $display("FAIL prio_d_first wr=%b addr=%h req wr=1 addr=200", mem_write, mem_address); end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = rand_line(); #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || dut_vec() !== model_vec())
      begin failures++; $display("FAIL prio_d_resp d=%b i=%b req d=1 i=0", d_resp, i_resp); end
    @(negedge clk);
    mem_resp = 1'b0; d_write = 1'b0; #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0)
      begin failures++; $display("FAIL prio_gap rd=%b wr=%b req 0 0", mem_read, mem_write); end
    @(negedge clk); #1;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h100 || dut_vec() !== model_vec())
      begin failures++; $display("FAIL prio_i_second rd=%b addr=%h req rd=1 addr=100", mem_read, mem_address); end
    @(negedge clk);
    mem_resp = 1'b1; #1;
    @(negedge clk);
    mem_resp = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_alternate();
    int g[$];
    int served;
    bit prev_busy, busy, i_done, d_done;
    int exp_g[4];
    exp_g = '{2, 1, 2, 1};
    served = 0; prev_busy = 1'b0; i_done = 1'b0; d_done = 1'b0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (i_done) i_read = 1'b0;
      else if (!i_read && g.size() < 4) begin
        i_read = 1'b1; i_address = 32'h1000_0000 | ($urandom & 32'h0FFF_FFE0);
      end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
      else if (!d_read && !d_write && g.size() < 4) begin
        d_read = 1'b1; d_address = 32'h2000_0000 | ($urandom & 32'h0FFF_FFE0);
      end
      served = (owner != 0) ? served + 1 : 0;
      mem_resp = (served >= 2);
      mem_rdata = rand_line();
      i_done = (owner == 1) && mem_resp;
      d_done = (owner == 2) && mem_resp;
      #1;
      checks++;
      if (dut_vec() !== model_vec())
        begin failures++; $display("FAIL alternate cyc=%0d act=%h exp=%h", c, dut_vec(), model_vec()); end
      busy = mem_read | mem_write;
      if (busy && !prev_busy) g.push_back(int'(mem_address[31:28]));
      prev_busy = busy;
      if (g.size() >= 4 && owner == 0 && !i_read && !d_read && !d_write && !i_done && !d_done) break;
    end
    checks++;
    if (g.size() < 4)
      begin failures++; $display("FAIL alternate_count grants=%0d req>=4", g.size()); end
    else
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g[k] !== exp_g[k])
          begin failures++; $display("FAIL alternate_order idx=%0d got=%0d req=%0d", k, g[k], exp_g[k]); end
      end
    @(negedge clk);
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_long_wait();
    logic [LW-1:0] line;
    @(negedge clk);
    d_read = 1'b1; d_address = 32'h0000_0340; mem_resp = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_rdata = rand_line(); #1;
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h340 ||
          i_resp !== 1'b0 || d_resp !== 1'b0 || dut_vec() !== model_vec())
        begin failures++; $display("FAIL long_wait cyc=%0d rd=%b addr=%h iresp=%b dresp=%b", c, mem_read, mem_address, i_resp, d_resp); end
    end
    @(negedge clk);
    line = rand_line(); mem_rdata = line; mem_resp = 1'b1; #1;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== line || i_resp !== 1'b0)
      begin failures++; $display("FAIL long_wait_resp d=%b i=%b req d=1 i=0", d_resp, i_resp); end
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b0; #1;
    checks++;
    if (d_resp !== 1'b0 || mem_read !== 1'b0)
      begin failures++; $display("FAIL long_wait_pulse d=%b rd=%b req 0 0", d_resp, mem_read); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_read = 1'b1; d_address = 32'h0000_03C0; mem_rdata = rand_line();
    @(negedge clk); #1;
    checks++;
    if (mem_read !== 1'b1 || dut_vec() !== model_vec())
      begin failures++; $display("FAIL rstmid_grant rd=%b req=1", mem_read); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== '0)
      begin failures++; $display("FAIL rstmid_async act=%h req=0", dut_vec()); end
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_resp = 1'b1; #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || dut_vec() !== model_vec())
      begin failures++; $display("FAIL rstmid_stray i=%b d=%b req 0 0", i_resp, d_resp); end
    @(negedge clk);
    mem_resp = 1'b0; #1;
    checks++;
    if (dut_vec() !== '0)
      begin failures++; $display("FAIL rstmid_idle act=%h req=0", dut_vec()); end
  endtask

  task automatic test_both_rw();
    logic [LW-1:0] wd;
    @(negedge clk);
    wd = rand_line();
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0480; d_wdata = wd;
    @(negedge clk); #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== wd || dut_vec() !== model_vec())
      begin failures++; $display("FAIL both_rw wr=%b rd=%b req wr=1 rd=0", mem_write, mem_read); end
    @(negedge clk);
    mem_resp = 1'b1; #1;
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_random();
    bit i_done, d_done, drain;
    i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 420; c++) begin
      drain = (c >= 400);
      @(negedge clk);
      if (i_done) i_read = 1'b0;
      else if (!i_read && !drain && $urandom_range(3) == 0) begin
        i_read = 1'b1; i_address = $urandom & 32'hFFFF_FFE0;
      end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
      else if (!d_read && !d_write && !drain && $urandom_range(3) == 0) begin
        case ($urandom_range(4))
          0, 1: d_read = 1'b1;
          2, 3: d_write = 1'b1;
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_address = $urandom & 32'hFFFF_FFE0;
        d_wdata = rand_line();
      end
      mem_rdata = rand_line();
      if (drain) mem_resp = (owner != 0);
      else if (owner != 0) mem_resp = ($urandom_range(2) == 0);
      else mem_resp = ($urandom_range(7) == 0);
      i_done = (owner == 1) && mem_resp;
      d_done = (owner == 2) && mem_resp;
      #1;
      checks++;
      if (dut_vec() !== model_vec())
        begin failures++; $display("FAIL random cyc=%0d act=%h exp=%h", c, dut_vec(), model_vec()); end
    end
    @(negedge clk);
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_alone();
    test_priority();
    test_alternate();
    test_long_wait();
    test_reset_mid();
    test_both_rw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
